// File: rtl/mips_memory_data_responder_pkg.sv
// ============================================================================
// mips_memory_data_responder_pkg: shared encodings for the memory-stage responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_memory_data_responder_pkg;

  typedef enum logic [1:0] {
    BE_NONE = 2'd0,
    BE_BYTE = 2'd1,
    BE_HALF = 2'd2,
    BE_INT  = 2'd3
  } byte_enable_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_TIMEOUT    = 2'd2
  } fault_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  function automatic logic is_misaligned(byte_enable_t size, logic [1:0] lo);
    return ((size == BE_HALF) && lo[0]) || ((size == BE_INT) && (lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_memory_data_responder_if.sv
// ============================================================================
// mips_memory_data_responder_if: request/acknowledge word bus to data memory
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mips_memory_data_responder_if;
  logic        busRequest;
  logic        busWrite;
  logic [29:0] busAddress;
  logic [3:0]  busByteMask;
  logic [31:0] busWriteData;
  logic [31:0] busReadData;
  logic        busAck;

  modport master (
    output busRequest, busWrite, busAddress, busByteMask, busWriteData,
    input  busReadData, busAck
  );

  modport slave (
    input  busRequest, busWrite, busAddress, busByteMask, busWriteData,
    output busReadData, busAck
  );
endinterface

`default_nettype wire

// File: rtl/mips_memory_lane_align.sv
// ============================================================================
// mips_memory_lane_align: byte-lane mask, store replication, load extraction
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_memory_lane_align
  import mips_memory_data_responder_pkg::*;
(
  input  byte_enable_t size,
  input  logic [1:0]   addr_lo,
  input  logic         sign_ext,
  input  logic [31:0]  store_in,
  input  logic [31:0]  load_word,
  output logic [3:0]   mask,
  output logic [31:0]  store_out,
  output logic [31:0]  load_out
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = load_word >> {addr_lo, 3'b000};
    mask      = 4'b0000;
    store_out = 32'd0;
    load_out  = 32'd0;
    case (size)
      BE_BYTE: begin
        mask      = 4'b0001 << addr_lo;
        store_out = {4{store_in[7:0]}};
        load_out  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      BE_HALF: begin
        mask      = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_out = {2{store_in[15:0]}};
        load_out  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      BE_INT: begin
        mask      = 4'b1111;
        store_out = store_in;
        load_out  = shifted;
      end
      default: begin
        mask      = 4'b0000;
        store_out = 32'd0;
        load_out  = 32'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_memory_data_responder.sv
// ============================================================================
// mips_memory_data_responder: memory-stage load/store engine with stall and faults
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_memory_data_responder
  import mips_memory_data_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic        writeEnable,
  input  logic [1:0]  byteEnable,
  input  logic        signExtend,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic        done,
  output logic [31:0] loadData,
  output logic        fault,
  output logic [1:0]  faultCode,
  mips_memory_data_responder_if.master bus
);

  state_t       state;
  byte_enable_t acc_size;
  logic         acc_write;
  logic         acc_sign;
  logic [31:0]  acc_address;
  logic [31:0]  acc_wdata;
  logic [3:0]   acc_mask;
  logic [7:0]   wait_count;
  logic         timed_out;

  byte_enable_t be_in;
  logic         in_idle, in_access, in_respond;
  logic         start, misaligned, go, terminal;
  byte_enable_t sel_size;
  logic [1:0]   sel_lo;
  logic         sel_sign;
  logic [3:0]   lane_mask;
  logic [31:0]  lane_store, lane_load;

  assign be_in      = byte_enable_t'(byteEnable);
  assign in_idle    = (state == ST_IDLE);
  assign in_access  = (state == ST_ACCESS);
  assign in_respond = (state == ST_RESPOND);
  assign start      = in_idle && valid && (be_in != BE_NONE);
  assign misaligned = is_misaligned(be_in, address[1:0]);
  assign go         = start && !misaligned;
  assign terminal   = ((wait_count + 8'd1) == 8'(TIMEOUT_CYCLES));

  // One aligner serves both phases: live inputs at start, latched access afterwards.
  assign sel_size = in_idle ? be_in         : acc_size;
  assign sel_lo   = in_idle ? address[1:0]  : acc_address[1:0];
  assign sel_sign = in_idle ? signExtend    : acc_sign;

  mips_memory_lane_align u_lane_align (
    .size      (sel_size),
    .addr_lo   (sel_lo),
    .sign_ext  (sel_sign),
    .store_in  (storeData),
    .load_word (bus.busReadData),
    .mask      (lane_mask),
    .store_out (lane_store),
    .load_out  (lane_load)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      acc_size    <= BE_NONE;
      acc_write   <= 1'b0;
      acc_sign    <= 1'b0;
      acc_address <= 32'd0;
      acc_wdata   <= 32'd0;
      acc_mask    <= 4'd0;
      wait_count  <= 8'd0;
      timed_out   <= 1'b0;
      loadData    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            acc_size    <= be_in;
            acc_write   <= writeEnable;
            acc_sign    <= signExtend;
            acc_address <= address;
            acc_mask    <= lane_mask;
            acc_wdata   <= lane_store;
            wait_count  <= 8'd0;
            timed_out   <= 1'b0;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (bus.busAck) begin
            if (!acc_write) loadData <= lane_load;
            state <= ST_RESPOND;
          end else if (terminal) begin
            timed_out <= 1'b1;
            loadData  <= 32'd0;
            state     <= ST_RESPOND;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign stall     = go || in_access;
  assign done      = in_respond;
  assign fault     = (start && misaligned) || (in_respond && timed_out);
  assign faultCode = (start && misaligned)      ? FAULT_MISALIGNED :
                     (in_respond && timed_out)  ? FAULT_TIMEOUT    : FAULT_NONE;

  assign bus.busRequest   = in_access;
  assign bus.busWrite     = in_access && acc_write;
  assign bus.busAddress   = acc_address[31:2];
  assign bus.busByteMask  = acc_mask;
  assign bus.busWriteData = acc_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mips_memory_data_responder.sv
// Directed bench for mips_memory_data_responder with a four-cycle bus timeout.
`default_nettype none

module tb_mips_memory_data_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic        writeEnable = 1'b0;
  logic [1:0]  byteEnable = 2'd0;
  logic        signExtend = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] storeData = 32'd0;
  logic        stall, done, fault;
  logic [31:0] loadData;
  logic [1:0]  faultCode;

  int checks = 0;
  int errors = 0;

  mips_memory_data_responder_if bus ();

  mips_memory_data_responder #(.TIMEOUT_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .writeEnable (writeEnable),
    .byteEnable  (byteEnable),
    .signExtend  (signExtend),
    .address     (address),
    .storeData   (storeData),
    .stall       (stall),
    .done        (done),
    .loadData    (loadData),
    .fault       (fault),
    .faultCode   (faultCode),
    .bus         (bus.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one aligned access from an IDLE cycle; ack arrives after 'waits' wait cycles.
  task automatic run_access(input logic we, input logic [1:0] be, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input int waits, input logic [31:0] rd,
                            output int stalls, output logic [3:0] m,
                            output logic [31:0] wd, output logic w,
                            output logic [29:0] ba, output logic d,
                            output logic [31:0] ld);
    valid = 1'b1; writeEnable = we; byteEnable = be; signExtend = sgn;
    address = addr; storeData = sd;
    #1;
    stalls = stall ? 1 : 0;
    tick();
    valid = 1'b0; byteEnable = 2'd0; storeData = 32'd0; address = 32'd0;
    m = bus.busByteMask; wd = bus.busWriteData; w = bus.busWrite; ba = bus.busAddress;
    for (int i = 0; i <= waits; i++) begin
      if (stall) stalls++;
      bus.busAck = (i == waits);
      bus.busReadData = rd;
      tick();
    end
    bus.busAck = 1'b0;
    if (stall) stalls++;
    d  = done;
    ld = loadData;
    tick();
  endtask

  int          st;
  logic [3:0]  m;
  logic [31:0] wd, ld;
  logic        w, d;
  logic [29:0] ba;
  int          req_cycles;

  initial begin
    bus.busAck = 1'b0;
    bus.busReadData = 32'd0;
    tick();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fcode", 32'(faultCode), 32'd0);
    check("rst_req", 32'(bus.busRequest), 32'd0);
    check("rst_write", 32'(bus.busWrite), 32'd0);
    check("rst_addr", 32'(bus.busAddress), 32'd0);
    check("rst_mask", 32'(bus.busByteMask), 32'd0);
    check("rst_wdata", bus.busWriteData, 32'd0);
    check("rst_load", loadData, 32'd0);
    reset = 1'b1;
    tick();

    // byteEnable None is not an access
    valid = 1'b1; byteEnable = 2'd0; address = 32'h100; #1;
    check("none_stall", 32'(stall), 32'd0);
    tick();
    check("none_req", 32'(bus.busRequest), 32'd0);
    valid = 1'b0;

    // lw 0x100, two wait cycles
    run_access(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 2, 32'hDEADBEEF, st, m, wd, w, ba, d, ld);
    check("lw_addr", 32'(ba), 32'h40);
    check("lw_mask", 32'(m), 32'hF);
    check("lw_stalls", 32'(st), 32'd4);
    check("lw_done", 32'(d), 32'd1);
    check("lw_load", ld, 32'hDEADBEEF);
    check("lw_idle_done", 32'(done), 32'd0);

    // lb 0x103 signed / unsigned
    run_access(1'b0, 2'd1, 1'b1, 32'h103, 32'd0, 0, 32'h80FF1234, st, m, wd, w, ba, d, ld);
    check("lb_mask", 32'(m), 32'h8);
    check("lb_stalls", 32'(st), 32'd2);
    check("lb_load", ld, 32'hFFFFFF80);
    run_access(1'b0, 2'd1, 1'b0, 32'h103, 32'd0, 0, 32'h80FF1234, st, m, wd, w, ba, d, ld);
    check("lbu_load", ld, 32'h00000080);

    // sh 0x202
    run_access(1'b1, 2'd2, 1'b0, 32'h202, 32'h0000ABCD, 1, 32'h11111111, st, m, wd, w, ba, d, ld);
    check("sh_write", 32'(w), 32'd1);
    check("sh_mask", 32'(m), 32'hC);
    check("sh_wdata", wd, 32'hABCDABCD);
    check("sh_addr", 32'(ba), 32'h80);
    check("sh_done", 32'(d), 32'd1);
    check("sh_load_kept", ld, 32'h00000080);

    // lh 0x002 signed: upper half of the word
    run_access(1'b0, 2'd2, 1'b1, 32'h002, 32'd0, 0, 32'h80017777, st, m, wd, w, ba, d, ld);
    check("lh_mask", 32'(m), 32'h3 << 2);
    check("lh_load", ld, 32'hFFFF8001);

    // misaligned lw 0x101
    valid = 1'b1; writeEnable = 1'b0; byteEnable = 2'd3; address = 32'h101; #1;
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_code", 32'(faultCode), 32'd1);
    check("mis_stall", 32'(stall), 32'd0);
    tick();
    valid = 1'b0; byteEnable = 2'd0; #1;
    check("mis_req", 32'(bus.busRequest), 32'd0);
    check("mis_fault_clr", 32'(fault), 32'd0);

    // timeout after 4 ACCESS cycles
    valid = 1'b1; writeEnable = 1'b0; byteEnable = 2'd3; address = 32'h300;
    tick();
    valid = 1'b0; byteEnable = 2'd0;
    req_cycles = 0;
    for (int i = 0; i < 20 && bus.busRequest; i++) begin
      req_cycles++;
      tick();
    end
    check("to_req_cycles", 32'(req_cycles), 32'd4);
    check("to_done", 32'(done), 32'd1);
    check("to_fault", 32'(fault), 32'd1);
    check("to_code", 32'(faultCode), 32'd2);
    check("to_load", loadData, 32'd0);
    tick();
    bus.busAck = 1'b1; bus.busReadData = 32'hCAFEF00D;
    tick();
    check("late_ack_done", 32'(done), 32'd0);
    check("late_ack_req", 32'(bus.busRequest), 32'd0);
    check("late_ack_load", loadData, 32'd0);
    bus.busAck = 1'b0;

    // reset during ACCESS
    valid = 1'b1; byteEnable = 2'd3; address = 32'h400;
    tick();
    valid = 1'b0; byteEnable = 2'd0;
    check("rm_req_before", 32'(bus.busRequest), 32'd1);
    reset = 1'b0; bus.busAck = 1'b1; #1;
    check("rm_req_drop", 32'(bus.busRequest), 32'd0);
    check("rm_stall_drop", 32'(stall), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rm_ack_ignored", 32'(done), 32'd0);
    bus.busAck = 1'b0;
    run_access(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 0, 32'h12345678, st, m, wd, w, ba, d, ld);
    check("rm_after_stalls", 32'(st), 32'd2);
    check("rm_after_done", 32'(d), 32'd1);
    check("rm_after_load", ld, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_memory_data_responder.md
# mips_memory_data_responder

Memory-stage responder that consumes the memory control signals (write enable, byte enable) produced by the control decoder and carries out the data access on the external data-memory bus. It accepts one access per instruction, drives a request/acknowledge word bus with byte-lane masks, aligns store data and extracts and extends load data. It holds the pipeline through `stall` until the bus acknowledges, and it reports misalignment and bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, 255: ACCESS cycles without `busAck` before the access is aborted with a timeout fault; range 1..255.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `valid` in 1: the memory stage holds an instruction.
- `writeEnable` in 1: 1 = store, 0 = load.
- `byteEnable` in 2: access size. None=0, Byte=1, Half=2, Int=3.
- `signExtend` in 1: loads only. 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
- `address` in 32: byte address.
- `storeData` in 32: store value, right-justified.
- `stall` out 1: hold all pipeline stages this cycle.
- `done` out 1: one-cycle completion pulse.
- `loadData` out 32: extended load result. Valid when `done` && !store.
- `fault` out 1: one-cycle fault pulse.
- `faultCode` out 2: None=0, Misaligned=1, Timeout=2.
- `busRequest` out 1, `busWrite` out 1, `busAddress` out 30 (word address), `busByteMask` out 4, `busWriteData` out 32.
- `busReadData` in 32, `busAck` in 1.

## Operation
The block is a three-state machine: IDLE, ACCESS, RESPOND.

**IDLE**
- An access starts when `valid` && `byteEnable` != None.
- Misalignment is Half with `address[0]`=1, or Int with `address[1:0]`≠0.
  - Misaligned start: `fault`=1 and `faultCode`=Misaligned for that cycle, no bus activity, `stall`=0, state stays IDLE.
  - Aligned start: latch write flag, size, sign, address and aligned store data, clear the timeout counter, go to ACCESS.
- `byteEnable`=None: nothing happens, `stall`=0.

**ACCESS**
- `busRequest`=1. All `bus*` outputs come from latched values and stay stable until ack or abort.
- Byte-lane mask (little-endian):
  - Byte: 1<<`address[1:0]`.
  - Half: `address[1]` ? 1100 : 0011.
  - Int: 1111.
- Store data replication: Byte = {4{data[7:0]}}, Half = {2{data[15:0]}}, Int = data.
- On `busAck`=1: capture `busReadData` and go to RESPOND.
- Otherwise increment the counter. When it reaches `TIMEOUT_CYCLES`, drop the request, record Timeout, and go to RESPOND.

**RESPOND**
- `done`=1 and `stall`=0, so the pipeline advances at the end of this cycle. Return to IDLE.
- `valid` is ignored in this cycle.
- Load extraction: shift the captured word right by 8×`address[1:0]`, then sign- or zero-extend from 8 or 16 bits. Int loads are unextended.
- On timeout: `fault`=1, `faultCode`=Timeout, `loadData`=0.
- Stores leave `loadData` unchanged.

**Other rules**
- `busAck` outside ACCESS is ignored.
- Inputs are sampled only on the IDLE start cycle.

## Timing
- `stall` is combinational: 1 on the aligned-start cycle in IDLE and in every ACCESS cycle, 0 otherwise.
- Zero-wait bus (ack in the first ACCESS cycle):
  - cycle T: start, `stall`=1;
  - T+1: ACCESS with ack, `stall`=1;
  - T+2: RESPOND, `done`=1, `stall`=0.
- Each extra wait cycle adds one.
- Timeout: exactly `TIMEOUT_CYCLES` ACCESS cycles, then RESPOND.
- Back-to-back: the next instruction's start is seen in the IDLE cycle after RESPOND. Throughput is at most one access per 3 cycles.
- Reset values: state IDLE; `stall`, `done`, `fault`, `busRequest`, `busWrite`=0; `faultCode`=None; `busAddress`, `busByteMask`, `busWriteData`, `loadData`=0.
- Reset mid-ACCESS drops `busRequest` immediately (asynchronous). A late `busAck` after reset is ignored.

## Structure
- Shared package holds:
  - the byte-enable encoding (the existing memory-control constants; do not redefine them);
  - the `faultCode` constants;
  - the state encoding.
- Sub-module `mips_memory_lane_align` (purely combinational): mask generation, store replication, load shift and extension. It is reused by the instruction-fetch side later.
- The FSM, latches and timeout counter live in the top module.

## Test plan
- lw at 0x100, ack after 2 wait cycles, `busReadData`=0xDEADBEEF → `busAddress`=0x40, mask 1111, `stall` high for 4 cycles, then `done` with `loadData`=0xDEADBEEF.
- lb at 0x103 (signed), word 0x80FF1234 → mask 1000, `loadData`=0xFFFFFF80. The same access as lbu → 0x00000080.
- sh at 0x202, `storeData`=0x0000ABCD → `busWrite`=1, mask 1100, `busWriteData`=0xABCDABCD, `done` pulse, `loadData` unchanged.
- lw at 0x101 → one-cycle `fault`, Misaligned, no `busRequest`, `stall`=0.
- `TIMEOUT_CYCLES`=4, no ack → `busRequest` high 4 cycles, then `done`+`fault`, Timeout, `loadData`=0. A late `busAck` in IDLE is ignored.
- `reset` low during ACCESS → `busRequest`/`stall` drop immediately. After release, the block is in IDLE and the next lw completes normally.
